// File: rtl/pipelined_decode_stage.sv
// ID stage of a 5-stage RISC-V pipeline: decodes into the ID/EX register with load-use stall, branch flush and a saturating bubble counter.
// Optional macro ADDI_EN adds decoding of addi (opcode 0010011, funct3 000).
module pipelined_decode_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      Instruction,
  input  logic             InstrValid,
  input  logic             BranchTaken,
  output logic             Stall,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             BranchE,
  output logic             MemToRegE,
  output logic             ALUSrcE,
  output logic [1:0]       ALUControlE,
  output logic [XLEN-1:0]  ImmE,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic             ValidE,
  output logic             IllegalE,
  output logic [CNT_W-1:0] BubbleCount
);

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7_5;
  logic [4:0]      rs1, rs2, rd;
  logic            dec_reg_write, dec_mem_write, dec_branch, dec_mem_to_reg, dec_alu_src;
  logic [1:0]      dec_alu_ctrl;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  logic            rs1_used, rs2_used;
  logic            hazard;
  logic            bubble, counted_bubble;

  assign opcode   = Instruction[6:0];
  assign funct3   = Instruction[14:12];
  assign funct7_5 = Instruction[30];
  assign rs1      = Instruction[19:15];
  assign rs2      = Instruction[24:20];
  assign rd       = Instruction[11:7];

  always_comb begin
    dec_reg_write  = 1'b0;
    dec_mem_write  = 1'b0;
    dec_branch     = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_alu_src    = 1'b0;
    dec_alu_ctrl   = 2'b00;
    dec_imm        = '0;
    dec_illegal    = 1'b0;
    rs1_used       = 1'b0;
    rs2_used       = 1'b0;
    case (opcode)
      OP_LD: begin
        dec_reg_write  = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_alu_src    = 1'b1;
        dec_imm        = {{(XLEN-12){Instruction[31]}}, Instruction[31:20]};
        rs1_used       = 1'b1;
      end
      OP_SD: begin
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_imm       = {{(XLEN-12){Instruction[31]}}, Instruction[31:25], Instruction[11:7]};
        rs1_used      = 1'b1;
        rs2_used      = 1'b1;
      end
      OP_R: begin
        case ({funct3, funct7_5})
          4'b000_0: begin dec_reg_write = 1'b1; dec_alu_ctrl = 2'b00; end
          4'b000_1: begin dec_reg_write = 1'b1; dec_alu_ctrl = 2'b01; end
          4'b111_0: begin dec_reg_write = 1'b1; dec_alu_ctrl = 2'b10; end
          4'b110_0: begin dec_reg_write = 1'b1; dec_alu_ctrl = 2'b11; end
          default:  dec_illegal = 1'b1;
        endcase
        rs1_used = !dec_illegal;
        rs2_used = !dec_illegal;
      end
      OP_BEQ: begin
        dec_branch   = 1'b1;
        dec_alu_ctrl = 2'b01;
        dec_imm      = {{(XLEN-12){Instruction[31]}}, Instruction[7], Instruction[30:25],
                        Instruction[11:8], 1'b0};
        rs1_used     = 1'b1;
        rs2_used     = 1'b1;
      end
`ifdef ADDI_EN
      OP_IMM: begin
        if (funct3 == 3'b000) begin
          dec_reg_write = 1'b1;
          dec_alu_src   = 1'b1;
          dec_imm       = {{(XLEN-12){Instruction[31]}}, Instruction[31:20]};
          rs1_used      = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
`endif
      // All-zero word is the canonical NOP; every other unknown encoding is illegal.
      default: dec_illegal = (Instruction != 32'h0);
    endcase
  end

  // Load in EX whose destination feeds a source actually read by the decode instruction.
  assign hazard = ValidE && MemToRegE && (RdE != 5'd0) && InstrValid &&
                  ((rs1_used && (rs1 == RdE)) || (rs2_used && (rs2 == RdE)));

  assign Stall          = hazard && !BranchTaken && !rst;
  assign counted_bubble = BranchTaken || Stall;
  assign bubble         = counted_bubble || !InstrValid;

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      BranchE     <= 1'b0;
      MemToRegE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      ALUControlE <= 2'b00;
      ImmE        <= '0;
      Rs1E        <= 5'd0;
      Rs2E        <= 5'd0;
      RdE         <= 5'd0;
      ValidE      <= 1'b0;
      IllegalE    <= 1'b0;
    end else begin
      RegWriteE   <= dec_reg_write;
      MemWriteE   <= dec_mem_write;
      BranchE     <= dec_branch;
      MemToRegE   <= dec_mem_to_reg;
      ALUSrcE     <= dec_alu_src;
      ALUControlE <= dec_alu_ctrl;
      ImmE        <= dec_imm;
      Rs1E        <= rs1;
      Rs2E        <= rs2;
      RdE         <= rd;
      ValidE      <= 1'b1;
      IllegalE    <= dec_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      BubbleCount <= '0;
    end else if (counted_bubble && (BubbleCount != {CNT_W{1'b1}})) begin
      BubbleCount <= BubbleCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipelined_decode_stage.sv
// Directed-vector bench for pipelined_decode_stage; a second instance with CNT_W=2 exercises counter saturation.
module tb_pipelined_decode_stage;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     Instruction;
  logic            InstrValid;
  logic            BranchTaken;
  logic            Stall, RegWriteE, MemWriteE, BranchE, MemToRegE, ALUSrcE, ValidE, IllegalE;
  logic [1:0]      ALUControlE;
  logic [XLEN-1:0] ImmE;
  logic [4:0]      Rs1E, Rs2E, RdE;
  logic [15:0]     BubbleCount;

  logic            sat_stall, sat_reg_write, sat_mem_write, sat_branch, sat_mem_to_reg, sat_alu_src;
  logic            sat_valid, sat_illegal;
  logic [1:0]      sat_alu_ctrl;
  logic [XLEN-1:0] sat_imm;
  logic [4:0]      sat_rs1, sat_rs2, sat_rd;
  logic [1:0]      sat_count;

  int n_vec = 0;
  int n_err = 0;

  pipelined_decode_stage #(.XLEN(XLEN), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .Instruction(Instruction), .InstrValid(InstrValid),
    .BranchTaken(BranchTaken), .Stall(Stall), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .MemToRegE(MemToRegE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .ImmE(ImmE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE), .IllegalE(IllegalE),
    .BubbleCount(BubbleCount)
  );

  pipelined_decode_stage #(.XLEN(XLEN), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .Instruction(Instruction), .InstrValid(InstrValid),
    .BranchTaken(BranchTaken), .Stall(sat_stall), .RegWriteE(sat_reg_write),
    .MemWriteE(sat_mem_write), .BranchE(sat_branch), .MemToRegE(sat_mem_to_reg),
    .ALUSrcE(sat_alu_src), .ALUControlE(sat_alu_ctrl), .ImmE(sat_imm), .Rs1E(sat_rs1),
    .Rs2E(sat_rs2), .RdE(sat_rd), .ValidE(sat_valid), .IllegalE(sat_illegal),
    .BubbleCount(sat_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic valid, input logic taken);
    Instruction = instr;
    InstrValid  = valid;
    BranchTaken = taken;
  endtask

  localparam logic [31:0] I_LD     = 32'h36A33503; // ld  x10,874(x6)
  localparam logic [31:0] I_LD_NEG = 32'hFF833503; // ld  x10,-8(x6)
  localparam logic [31:0] I_LD_RS2 = 32'h00A33083; // ld  x1,10(x6): rs2 field = 10 but unused
  localparam logic [31:0] I_ADD    = 32'h00A30533; // add x10,x6,x10
  localparam logic [31:0] I_SUB    = 32'h40A30533;
  localparam logic [31:0] I_AND    = 32'h00A37533;
  localparam logic [31:0] I_OR     = 32'h00A36533;
  localparam logic [31:0] I_BEQ    = 32'h14A30563; // beq x6,x10,330
  localparam logic [31:0] I_SD     = 32'h00A33423; // sd  x10,8(x6)
  localparam logic [31:0] I_BADR   = 32'h00A31533; // R-type funct3 001: not supported
  localparam logic [31:0] I_ADDI   = 32'h00000013;

  initial begin
    rst = 1'b1;
    drive(32'($urandom_range(0, 32'hFFFF_FFFF)), 1'b1, 1'b0);
    tick();
    drive(I_ADD, 1'b1, 1'b1);
    tick();
    check("rst_valid", ValidE, 1'b0);
    check("rst_regwrite", RegWriteE, 1'b0);
    check("rst_imm", ImmE, 64'd0);
    check("rst_rd", RdE, 5'd0);
    check("rst_count", BubbleCount, 16'd0);
    check("rst_stall", Stall, 1'b0);

    // ld then dependent add: one bubble
    rst = 1'b0;
    drive(I_LD, 1'b1, 1'b0);
    check("ld_no_stall", Stall, 1'b0);
    tick();
    check("ld_regwrite", RegWriteE, 1'b1);
    check("ld_memtoreg", MemToRegE, 1'b1);
    check("ld_alusrc", ALUSrcE, 1'b1);
    check("ld_aluctl", ALUControlE, 2'd0);
    check("ld_imm", ImmE, 64'd874);
    check("ld_rs1", Rs1E, 5'd6);
    check("ld_rd", RdE, 5'd10);
    check("ld_valid", ValidE, 1'b1);
    drive(I_ADD, 1'b1, 1'b0);
    #1 check("loaduse_stall", Stall, 1'b1);
    tick();
    check("bubble_valid", ValidE, 1'b0);
    check("bubble_regwrite", RegWriteE, 1'b0);
    check("bubble_count1", BubbleCount, 16'd1);
    check("stall_cleared", Stall, 1'b0);
    tick();
    check("add_valid", ValidE, 1'b1);
    check("add_aluctl", ALUControlE, 2'd0);
    check("add_rs2", Rs2E, 5'd10);
    check("add_rs1", Rs1E, 5'd6);
    check("add_alusrc", ALUSrcE, 1'b0);
    check("add_imm", ImmE, 64'd0);

    drive(I_SUB, 1'b1, 1'b0);
    tick();
    check("sub_aluctl", ALUControlE, 2'd1);
    check("sub_regwrite", RegWriteE, 1'b1);
    check("sub_alusrc", ALUSrcE, 1'b0);
    drive(I_AND, 1'b1, 1'b0);
    tick();
    check("and_aluctl", ALUControlE, 2'd2);
    check("and_regwrite", RegWriteE, 1'b1);
    drive(I_OR, 1'b1, 1'b0);
    tick();
    check("or_aluctl", ALUControlE, 2'd3);
    check("or_alusrc", ALUSrcE, 1'b0);

    drive(I_BEQ, 1'b1, 1'b0);
    tick();
    check("beq_branch", BranchE, 1'b1);
    check("beq_aluctl", ALUControlE, 2'd1);
    check("beq_imm", ImmE, 64'd330);
    check("beq_regwrite", RegWriteE, 1'b0);

    // flush overrides a load-use stall
    drive(I_LD, 1'b1, 1'b0);
    tick();
    drive(I_ADD, 1'b1, 1'b1);
    #1 check("flush_stall", Stall, 1'b0);
    tick();
    check("flush_valid", ValidE, 1'b0);
    check("flush_count2", BubbleCount, 16'd2);

    // negative immediate, then a fetch bubble on a would-be hazard
    drive(I_LD_NEG, 1'b1, 1'b0);
    tick();
    check("ldneg_imm", ImmE, 64'hFFFF_FFFF_FFFF_FFF8);
    drive(I_ADD, 1'b0, 1'b0);
    #1 check("invalid_no_stall", Stall, 1'b0);
    tick();
    check("invalid_valid", ValidE, 1'b0);
    check("invalid_count", BubbleCount, 16'd2);

    // unused rs2 field matching the load destination must not stall
    drive(I_LD, 1'b1, 1'b0);
    tick();
    drive(I_LD_RS2, 1'b1, 1'b0);
    #1 check("unused_rs2_stall", Stall, 1'b0);
    tick();
    check("ldrs2_rd", RdE, 5'd1);
    check("ldrs2_rs2_pass", Rs2E, 5'd10);
    check("ldrs2_imm", ImmE, 64'd10);

    drive(I_SD, 1'b1, 1'b0);
    tick();
    check("sd_memwrite", MemWriteE, 1'b1);
    check("sd_imm", ImmE, 64'd8);
    check("sd_regwrite", RegWriteE, 1'b0);
    check("sd_alusrc", ALUSrcE, 1'b1);

    drive(32'h0, 1'b1, 1'b0);
    tick();
    check("nop_valid", ValidE, 1'b1);
    check("nop_illegal", IllegalE, 1'b0);
    check("nop_regwrite", RegWriteE, 1'b0);

    drive(I_BADR, 1'b1, 1'b0);
    tick();
    check("badr_illegal", IllegalE, 1'b1);
    check("badr_valid", ValidE, 1'b1);
    check("badr_regwrite", RegWriteE, 1'b0);

    drive(I_ADDI, 1'b1, 1'b0);
    tick();
    check("addi_valid", ValidE, 1'b1);
`ifdef ADDI_EN
    check("addi_alusrc", ALUSrcE, 1'b1);
    check("addi_illegal", IllegalE, 1'b0);
    check("addi_regwrite", RegWriteE, 1'b1);
`else
    check("addi_illegal", IllegalE, 1'b1);
    check("addi_regwrite", RegWriteE, 1'b0);
    check("addi_alusrc", ALUSrcE, 1'b0);
`endif

    // saturation: the CNT_W=2 copy is at 2 here
    check("sat_count_pre", sat_count, 2'd2);
    for (int i = 0; i < 3; i++) begin
      drive(I_ADD, 1'b1, 1'b1);
      tick();
    end
    check("sat_count_max", sat_count, 2'd3);
    check("count5", BubbleCount, 16'd5);

    // reset dominates a concurrent flush
    rst = 1'b1;
    drive(I_ADD, 1'b1, 1'b1);
    #1 check("rst_stall2", Stall, 1'b0);
    tick();
    check("rst2_count", BubbleCount, 16'd0);
    check("rst2_sat_count", sat_count, 2'd0);
    check("rst2_valid", ValidE, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_decode_stage.md
Name: pipelined_decode_stage

Overview:
- Next-generation RISC-V controller. Decodes a 32-bit instruction in the ID stage and registers all control, immediate and register indices into the ID/EX pipeline register.
- Adds three things the combinational controller lacks: load-use hazard detection with stall/bubble, branch flush, and a saturating bubble counter.
- Sits between the IF/ID register and the EX stage of the 5-stage pipeline. Immediate width is parametrised.

Parameters:
- XLEN, 64, datapath/immediate width; immediates are sign-extended to XLEN.
- CNT_W, 16, width of the BubbleCount saturating counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- Instruction  input  32  instruction from IF/ID register
- InstrValid  input  1  Instruction is a real instruction (0 = bubble from fetch)
- BranchTaken  input  1  EX-stage branch resolved taken this cycle
- Stall  output  1  combinational; hold PC and IF/ID this cycle
- RegWriteE  output  1  registered control to EX
- MemWriteE  output  1  registered control to EX
- BranchE  output  1  registered control to EX
- MemToRegE  output  1  registered control to EX
- ALUSrcE  output  1  registered control to EX; 1 = immediate operand
- ALUControlE  output  2  00 add, 01 sub, 10 and, 11 or
- ImmE  output  XLEN  sign-extended immediate
- Rs1E, Rs2E, RdE  output  5 each  register indices
- ValidE  output  1  EX slot holds a real instruction
- IllegalE  output  1  EX slot holds an undecodable instruction (ValidE=1, all write controls 0)
- BubbleCount  output  CNT_W  number of bubbles inserted since reset, saturating

Behaviour:
- Reset (rst=1 at posedge): all E outputs and BubbleCount go to 0. rst dominates every other input. Stall is 0 while rst=1.
- Decode, by opcode = Instruction[6:0]:
  - 0000011 ld: RegWrite, MemToReg, ALUSrc, add; I-imm [31:20].
  - 0100011 sd: MemWrite, ALUSrc, add; S-imm {[31:25],[11:7]}.
  - 0110011 R-type, selected by funct3/funct7[5]:
    - 000/0 add → 00
    - 000/1 sub → 01
    - 111/0 and → 10
    - 110/0 or → 11
  - 1100011 beq: Branch, sub; B-imm {[31],[7],[30:25],[11:8],0}.
  - 32'h0: NOP, ValidE=1, all controls 0.
  - Any other encoding: IllegalE=1, all controls 0.
  - Immediate is 0 for R-type and NOP.
- Register-use rules:
  - rs1 is used by ld, sd, R-type and beq.
  - rs2 is used by sd, R-type and beq.
  - Unused fields are still passed through to Rs1E/Rs2E, but never participate in hazard compare.
- Load-use hazard: Stall=1 when all of the following hold:
  - ValidE, MemToRegE and RdE≠0 (EX slot is a load with a nonzero destination);
  - InstrValid;
  - RdE equals a used rs1 or a used rs2 of the decode instruction.
- Next-state priority at each posedge (no rst):
  1. BranchTaken=1: bubble into EX; Stall forced to 0 (the flush overrides the stall).
  2. Else Stall=1: bubble into EX; upstream holds Instruction.
  3. Else InstrValid=0: bubble into EX.
  4. Else: load the decoded instruction, ValidE=1.
- Bubble definition: ValidE=0, IllegalE=0, all controls 0, ImmE=0, indices 0.
- BubbleCount increments by 1 for each bubble from cases 1 and 2 only, and saturates at 2^CNT_W−1 (no wrap).
- Latency: decode to E outputs is 1 cycle. A load-use pair costs exactly 1 bubble: on the next cycle ValidE=0, so the hazard clears.

Optional Feature:
- Macro ADDI_EN.
- When defined: opcode 0010011 with funct3 000 decodes as addi (RegWrite, ALUSrc, add, I-imm). rs1 is used and rs2 is unused for hazard compare.
- When undefined: opcode 0010011 decodes as illegal (IllegalE=1, controls 0).

Test Plan:
- rst=1 for 2 cycles with arbitrary Instruction → all E outputs 0, BubbleCount=0, Stall=0.
- Instruction 0x36A33503 (ld x10,874(x6)) → next cycle:
  - RegWriteE=1, MemToRegE=1, ALUSrcE=1, ALUControlE=00
  - ImmE=874, Rs1E=6, RdE=10, ValidE=1
- ld above followed by 0x00A30533 (add x10,x6,x10):
  - Stall=1 for one cycle; the bubble gives ValidE=0 and BubbleCount=1.
  - The following cycle the add appears with ALUControlE=00, Rs2E=10.
- 0x40A30533 (sub) → ALUControlE=01. 0x00A37533 (and) → 10. 0x00A36533 (or) → 11. All three with RegWriteE=1, ALUSrcE=0.
- 0x14A30563 (beq x6,x10,330) → BranchE=1, ALUControlE=01, ImmE=330. Then BranchTaken=1 together with a hazard-causing Instruction → Stall=0, ValidE=0, BubbleCount increments by 1.
- 0x00000013 (addi x0,x0,0) → with ADDI_EN: ValidE=1, ALUSrcE=1, IllegalE=0. Without ADDI_EN: IllegalE=1, RegWriteE=0. Also force BubbleCount to max with CNT_W=2 → it stays at 3 on further bubbles.
